cache_mem_ctrl: RTL and testbench
=================================

Name: cache_mem_ctrl

Overview:
Backing-memory controller directly downstream of the cache. It serves the cache's line-fill (read) and write-back (write) requests against a word-addressed main memory with configurable access latency. Lines transfer as fixed-length bursts with one word per beat. The controller exposes a valid/ready request port, a write-data beat handshake and a read-data beat stream.

Parameters:
- ADDR_W, 32, word-address width (same word addressing as the cache `addr`).
- DATA_W, 32, word width.
- LINE_WORDS, 4, words per cache line; power of two, at least 2.
- MEM_DEPTH, 1024, memory size in words; power of two.
- MEM_LAT, 4, access latency in cycles before the first beat; at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept a request.
- req_wr  in  1  1 = write-back, 0 = line fill.
- req_addr  in  ADDR_W  word address; the low log2(LINE_WORDS) bits are ignored (line-aligned).
- wdata  in  DATA_W  write beat data.
- wdata_valid  in  1  write beat present.
- wdata_ready  out  1  controller is accepting write beats.
- rdata  out  DATA_W  read beat data.
- rdata_valid  out  1  read beat valid (no backpressure).
- rdata_last  out  1  marks the final read beat of a line.
- busy  out  1  a transaction is in progress.

Behaviour:
- Reset (async assert, sync release):
  - State returns to IDLE.
  - req_ready=0 while rst_n=0, and 1 from the first cycle after release.
  - wdata_ready, rdata_valid, rdata_last and busy are all 0; rdata=0.
  - Memory contents are not cleared.
- FSM states are IDLE, LAT, BURST.
- IDLE:
  - req_ready=1.
  - An accept occurs on an edge where req_valid && req_ready. At that edge the controller captures req_wr and the line base address (req_addr with offset bits zeroed, taken modulo MEM_DEPTH), loads lat_cnt=MEM_LAT-1 and moves to LAT.
- LAT:
  - busy=1, req_ready=0.
  - lat_cnt decrements each cycle. When lat_cnt=0, the next state is BURST with beat_cnt=0.
- BURST, read:
  - rdata_valid=1 for exactly LINE_WORDS consecutive cycles, carrying words base+0 through base+LINE_WORDS-1 in ascending order.
  - rdata_last=1 on beat LINE_WORDS-1 only.
  - The first beat is sampled at the edge MEM_LAT+1 cycles after the accept edge.
  - rdata and rdata_valid are driven from registers.
- BURST, write:
  - wdata_ready=1 throughout BURST.
  - Each edge with wdata_valid=1 writes wdata to base+beat_cnt and increments beat_cnt.
  - wdata_valid=0 stalls the burst indefinitely with no timeout.
- Exit and back-to-back:
  - After the final beat the next state is IDLE, so req_ready=1 the following cycle.
  - Minimum spacing between accepts is MEM_LAT+LINE_WORDS+1 cycles.
- Boundary conditions:
  - req_valid while busy is ignored and not queued. The requester holds req_valid until it sees req_ready.
  - wdata_valid outside a write BURST is ignored.
  - Address wrap: the word index is (base+beat) mod MEM_DEPTH. Upper address bits beyond log2(MEM_DEPTH) alias.
  - rst_n asserted mid-transaction aborts it immediately. Write beats already committed stay in memory; beats not yet accepted are dropped; the line is left partially written.
  - beat_cnt is log2(LINE_WORDS) bits wide and is never allowed to overflow; the last beat forces the transition to IDLE.

Decomposition:
- Package cache_pkg holds:
  - ADDR_W, DATA_W, LINE_WORDS and derived OFS_W=log2(LINE_WORDS);
  - the state enum {IDLE, LAT, BURST};
  - a req_t struct {wr, addr}.
- One sub-module, mem_array: a single-port synchronous RAM (MEM_DEPTH x DATA_W) with one-cycle registered read. The controller presents each read address one cycle ahead of its beat, so beat timing is exactly as specified.

Test Plan:
1. Write-back then fill. Write at req_addr=0x10, beats 0x01, 0x02, 0x03, 0x04, then fill at req_addr=0x12 → rdata sequence 0x01, 0x02, 0x03, 0x04. rdata_last is set on the 4th beat only, and the low address bits are shown to be ignored.
2. Latency check (MEM_LAT=4). Fill accepted at edge E → first rdata_valid sampled at E+5. rdata_valid stays high for 4 consecutive cycles, and req_ready returns to 1 at E+9.
3. Write stall. Drop wdata_valid for 3 cycles after beat 1 → beat_cnt holds, no spurious write, and the burst completes correctly when valid resumes. Read-back matches.
4. Reset mid-burst. Write line 0x20 with 0xAA..., assert rst_n=0 after beat 1 → all outputs 0 immediately and req_ready=1 after release. A fill of 0x20 returns beats 0-1 new and beats 2-3 old.
5. Busy rejection and wrap. Hold req_valid during LAT → no second accept until IDLE. A write to req_addr=MEM_DEPTH+4 is read back at req_addr=4.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and line geometry for the cache backing-memory controller.
package cache_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int OFS_W      = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LAT   = 2'd1,
    BURST = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
  } req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port; only the read
// register is reset, the array contents survive reset.
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= WIDTH'(0);
    end else begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/cache_mem_ctrl.sv
// Line-fill / write-back controller between the cache and a word-addressed
// main memory with fixed access latency and one-word-per-beat bursts.
module cache_mem_ctrl
  import cache_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              rdata_last,
  output logic              busy
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam logic [OFS_W-1:0] LAST_BEAT = OFS_W'(LINE_WORDS - 1);

  state_t           state_r, state_n;
  req_t             req_r, req_n;
  logic [LAT_W-1:0] lat_r, lat_n;
  logic [OFS_W-1:0] beat_r, beat_n;
  logic             req_ready_r, busy_r, wdata_ready_r, rdata_valid_r, rdata_last_r;
  logic             mem_we_s;
  logic [OFS_W-1:0] mem_ofs_s;
  logic [IDX_W-1:0] mem_idx_s;
  logic             unused_addr_s;

  // next-state, counters and memory write strobe
  always_comb begin
    state_n  = state_r;
    req_n    = req_r;
    lat_n    = lat_r;
    beat_n   = beat_r;
    mem_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          req_n.wr   = req_wr;
          req_n.addr = req_addr & ~ADDR_W'(LINE_WORDS - 1);
          lat_n      = LAT_W'(MEM_LAT - 1);
          state_n    = LAT;
        end else begin
          state_n = IDLE;
        end
      end
      LAT: begin
        if (lat_r == LAT_W'(0)) begin
          beat_n  = OFS_W'(0);
          state_n = BURST;
        end else begin
          lat_n = lat_r - LAT_W'(1);
        end
      end
      BURST: begin
        // write beats advance only on wdata_valid; read beats every cycle
        if (req_r.wr && !wdata_valid) begin
          state_n = BURST;
        end else begin
          mem_we_s = req_r.wr;
          if (beat_r == LAST_BEAT) begin
            state_n = IDLE;
          end else begin
            beat_n = beat_r + OFS_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // RAM address: reads run one word ahead so the registered RAM output lines up with the beat
  always_comb begin
    mem_ofs_s = OFS_W'(0);
    if (state_r == BURST) begin
      if (req_r.wr) begin
        mem_ofs_s = beat_r;
      end else begin
        mem_ofs_s = beat_r + OFS_W'(1);
      end
    end else begin
      mem_ofs_s = OFS_W'(0);
    end
  end

  assign mem_idx_s     = {req_r.addr[IDX_W-1:OFS_W], mem_ofs_s};
  assign unused_addr_s = ^{req_r.addr[ADDR_W-1:IDX_W], req_r.addr[OFS_W-1:0]};

  // state, request capture and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      req_r         <= '{wr: 1'b0, addr: ADDR_W'(0)};
      lat_r         <= LAT_W'(0);
      beat_r        <= OFS_W'(0);
      req_ready_r   <= 1'b0;
      busy_r        <= 1'b0;
      wdata_ready_r <= 1'b0;
      rdata_valid_r <= 1'b0;
      rdata_last_r  <= 1'b0;
    end else begin
      state_r       <= state_n;
      req_r         <= req_n;
      lat_r         <= lat_n;
      beat_r        <= beat_n;
      req_ready_r   <= (state_n == IDLE);
      busy_r        <= (state_n != IDLE);
      wdata_ready_r <= (state_n == BURST) && req_n.wr;
      rdata_valid_r <= (state_n == BURST) && !req_n.wr;
      rdata_last_r  <= (state_n == BURST) && !req_n.wr && (beat_n == LAST_BEAT);
    end
  end

  mem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (DATA_W),
    .AW    (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_s),
    .addr  (mem_idx_s),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign req_ready   = req_ready_r;
  assign busy        = busy_r;
  assign wdata_ready = wdata_ready_r;
  assign rdata_valid = rdata_valid_r;
  assign rdata_last  = rdata_last_r;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl: cycle-level behavioural model plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_cache_mem_ctrl;

  localparam int D   = 1024;
  localparam int LAT = 4;
  localparam int LW  = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, wdata, rdata;
  logic        wdata_valid, wdata_ready, rdata_valid, rdata_last, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  logic [31:0] wbuf [LW];
  logic [31:0] rbuf [LW];
  logic        rlast [LW];
  int rcount, acc_c, first_c, rdy_c;

  // model: memory image plus transaction progress measured in edges since accept
  logic [31:0] mem_m [D];
  bit          known_m [D];
  bit          m_active = 0;
  bit          m_wr = 0;
  bit          m_ready = 0;
  int          m_base = 0, m_since = 0, m_beats = 0;

  cache_mem_ctrl #(.MEM_DEPTH(D), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // behavioural model, stepped on every edge
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 0;
      m_ready  = 0;
    end else begin
      if (!m_active) begin
        if (req_valid && m_ready) begin
          m_active = 1;
          m_wr     = req_wr;
          m_base   = (int'(req_addr % D) / LW) * LW;
          m_since  = 0;
          m_beats  = 0;
        end
      end else begin
        if (m_since >= LAT) begin
          if (m_wr) begin
            if (wdata_valid) begin
              mem_m[(m_base + m_beats) % D]   = wdata;
              known_m[(m_base + m_beats) % D] = 1;
              m_beats++;
              if (m_beats == LW) m_active = 0;
            end
          end else if (m_since - LAT == LW - 1) begin
            m_active = 0;
          end
        end
        m_since++;
      end
      m_ready = !m_active;
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    bit burst, rv;
    int beat, ix;
    @(negedge clk);
    if (chk_en) begin
      burst = m_active && (m_since >= LAT);
      rv    = burst && !m_wr;
      beat  = m_since - LAT;
      chk("req_ready", 32'(req_ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(m_active));
      chk("wdata_ready", 32'(wdata_ready), 32'(burst && m_wr));
      chk("rdata_valid", 32'(rdata_valid), 32'(rv));
      chk("rdata_last", 32'(rdata_last), 32'(rv && (beat == LW - 1)));
      if (rv) begin
        ix = (m_base + beat) % D;
        if (known_m[ix]) chk("rdata", rdata, mem_m[ix]);
      end
      if (!rst_n) chk("rdata_in_reset", rdata, 32'h0);
    end
  end

  task automatic issue(input bit wr, input logic [31:0] a);
    bit ok;
    ok = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    for (int t = 0; t < 200; t++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    acc_c = cyc;
    req_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_abort();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wdata_ready", 32'(wdata_ready), 32'd0);
    chk("abort_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("abort_rdata_last", 32'(rdata_last), 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    wdata_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_after_release", 32'(req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input int stall_beat, input int stall_n,
                          input int abort_after);
    bit ok;
    issue(1'b1, a);
    for (int b = 0; b < LW; b++) begin
      if (b == abort_after) begin
        do_abort();
        return;
      end
      if (b == stall_beat) begin
        wdata_valid = 1'b0;
        wdata = 32'hDEAD_BEEF;
        repeat (stall_n) begin
          @(posedge clk); #1;
        end
      end
      wdata_valid = 1'b1;
      wdata = wbuf[b];
      ok = 0;
      for (int t = 0; t < 100; t++) begin
        if (wdata_ready) begin
          @(posedge clk); #1;
          ok = 1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!ok) chk("wbeat_timeout", 32'd0, 32'd1);
    end
    wdata_valid = 1'b0;
    wait_idle();
  endtask

  task automatic do_read(input logic [31:0] a, input bit noise);
    issue(1'b0, a);
    rcount = 0;
    first_c = -1;
    rdy_c = -1;
    for (int t = 0; t < 60; t++) begin
      if (rdata_valid) begin
        if (rcount < LW) begin
          rbuf[rcount]  = rdata;
          rlast[rcount] = rdata_last;
        end
        if (first_c < 0) first_c = cyc;
        rcount++;
      end
      if (req_ready) begin
        rdy_c = cyc;
        break;
      end
      wdata_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      wdata = $urandom;
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    chk("read_beat_count", 32'(rcount), 32'(LW));
    if (rdy_c < 0) chk("read_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int acc [2];
    int n;
    logic [31:0] ra;
    rst_n = 1'b1;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = 32'h0;
    wdata = 32'h0;
    wdata_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready_low", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready_after", 32'(req_ready), 32'd1);

    // write-back then fill with unaligned address; latency and turnaround
    for (int i = 0; i < LW; i++) wbuf[i] = 32'(i + 1);
    do_write(32'h10, LW, 0, LW);
    do_read(32'h12, 1'b0);
    for (int i = 0; i < LW; i++) begin
      chk("t1_data", rbuf[i], 32'(i + 1));
      chk("t1_last", 32'(rlast[i]), 32'(i == LW - 1));
    end
    chk("t2_first_beat_edge", 32'(first_c + 1 - acc_c), 32'd5);
    chk("t2_ready_edge", 32'(rdy_c + 1 - acc_c), 32'd9);

    // write with a 3-cycle stall after beat 1
    for (int i = 0; i < LW; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    do_write(32'h30, 2, 3, LW);
    do_read(32'h30, 1'b1);
    for (int i = 0; i < LW; i++) chk("t3_data", rbuf[i], 32'hC0DE_0000 + 32'(i));

    // reset after two committed beats leaves the line half old, half new
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_write(32'h20, LW, 0, LW);
    wbuf[0] = 32'hAA; wbuf[1] = 32'hAB; wbuf[2] = 32'hAC; wbuf[3] = 32'hAD;
    do_write(32'h20, LW, 0, 2);
    do_read(32'h20, 1'b0);
    chk("t4_beat0", rbuf[0], 32'hAA);
    chk("t4_beat1", rbuf[1], 32'hAB);
    chk("t4_beat2", rbuf[2], 32'h33);
    chk("t4_beat3", rbuf[3], 32'h44);

    // request held while busy: second accept only once idle again
    n = 0;
    req_valid = 1'b1;
    req_wr = 1'b0;
    req_addr = 32'h10;
    for (int t = 0; t < 60 && n < 2; t++) begin
      if (req_ready) begin
        acc[n] = cyc + 1;
        n++;
      end
      @(posedge clk); #1;
      if (n == 1) req_addr = 32'h30;
    end
    req_valid = 1'b0;
    chk("t5_accepts", 32'(n), 32'd2);
    if (n == 2) chk("t5_accept_spacing", 32'(acc[1] - acc[0]), 32'd9);
    wait_idle();

    // address wrap / alias
    for (int i = 0; i < LW; i++) wbuf[i] = 32'h5A5A_0000 + 32'(i);
    do_write(32'(D + 4), LW, 0, LW);
    do_read(32'h4, 1'b0);
    for (int i = 0; i < LW; i++) chk("t5_wrap_data", rbuf[i], 32'h5A5A_0000 + 32'(i));

    // randomized traffic over a few lines with aliased upper address bits
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) begin
        wdata_valid = 1'($urandom_range(0, 1));
        wdata = $urandom;
        @(posedge clk); #1;
      end
      wdata_valid = 1'b0;
      ra = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < LW; i++) wbuf[i] = $urandom;
        do_write(ra, $urandom_range(0, LW), $urandom_range(0, 2), LW);
      end else begin
        do_read(ra, 1'b1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
